// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, ALU opsel codes, issue entry.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package alu_pkg;

  // RV32I major opcodes handled by the issue stage
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // ALU operation select; matches funct3 of the OP/OP-IMM groups
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SR   = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  // The two funct7 values the base ISA allows for register ops and shifts
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // One decoded instruction as handed to the execute stage
  typedef struct packed {
    logic [2:0]  opsel;
    logic        sub;
    logic        is_unsigned;
    logic        arith;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        illegal;
  } issue_t;

  // Occupancy of the two-entry skid buffer
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Decodes one RV32I instruction into ALU controls and operands.
// Latency: purely combinational.
// Backpressure: none; the enclosing stage decides when the result is captured.
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_rs1_rdata,
  input  logic [31:0] i_rs2_rdata,
  output issue_t      o_entry
);

  logic [2:0] f3;
  logic [6:0] f7;
  logic       f7_ok;

  assign f3    = i_inst[14:12];
  assign f7    = i_inst[31:25];
  assign f7_ok = (f7 == F7_BASE) || (f7 == F7_ALT);

  // Opcode-driven decode; every field not named by an opcode stays zero
  always_comb begin
    o_entry    = '0;
    o_entry.rd = i_inst[11:7];
    case (i_inst[6:0])
      OPC_OP: begin
        o_entry.opsel       = f3;
        o_entry.op1         = i_rs1_rdata;
        o_entry.op2         = i_rs2_rdata;
        o_entry.sub         = f7[5] && (f3 == ALU_ADD);
        o_entry.arith       = f7[5] && (f3 == ALU_SR);
        o_entry.is_unsigned = (f3 == ALU_SLTU);
        o_entry.illegal     = !f7_ok || ((f7 == F7_ALT) && (f3 != ALU_ADD) && (f3 != ALU_SR));
      end
      OPC_OPIMM: begin
        o_entry.opsel       = f3;
        o_entry.op1         = i_rs1_rdata;
        // Shifts carry a 5-bit shamt; funct7 bits are not part of the operand
        if ((f3 == ALU_SLL) || (f3 == ALU_SR)) begin
          o_entry.op2 = {27'b0, i_inst[24:20]};
        end else begin
          o_entry.op2 = sext12(i_inst[31:20]);
        end
        o_entry.arith       = i_inst[30] && (f3 == ALU_SR);
        o_entry.is_unsigned = (f3 == ALU_SLTU);
        o_entry.illegal     = ((f3 == ALU_SLL) && (f7 != F7_BASE)) ||
                              ((f3 == ALU_SR) && !f7_ok);
      end
      OPC_BRANCH: begin
        // Branches compare via set-less-than; f3[1] picks the unsigned forms
        o_entry.opsel       = ALU_SLT;
        o_entry.op1         = i_rs1_rdata;
        o_entry.op2         = i_rs2_rdata;
        o_entry.is_unsigned = f3[1];
        o_entry.illegal     = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LOAD: begin
        o_entry.op1 = i_rs1_rdata;
        o_entry.op2 = sext12(i_inst[31:20]);
      end
      OPC_STORE: begin
        o_entry.op1 = i_rs1_rdata;
        o_entry.op2 = sext12({i_inst[31:25], i_inst[11:7]});
      end
      OPC_LUI: begin
        o_entry.op2 = {i_inst[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        o_entry.op1 = i_pc;
        o_entry.op2 = {i_inst[31:12], 12'b0};
      end
      OPC_JAL, OPC_JALR: begin
        // ALU produces the link value pc+4
        o_entry.op1 = i_pc;
        o_entry.op2 = 32'd4;
      end
      default: begin
        // Still issued so execute can raise the trap in order
        o_entry.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage: decodes RV32I instructions into ALU controls and operands.
// Latency: an instruction accepted in cycle N is presented on the outputs in cycle N+1.
// Backpressure: 2-entry skid buffer; o_ready is a flop, low only while both entries are full.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int RESET_PC_UNUSED = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_rs1_rdata,
  input  logic [31:0] i_rs2_rdata,
  input  logic        i_flush,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [2:0]  o_opsel,
  output logic        o_sub,
  output logic        o_unsigned,
  output logic        o_arith,
  output logic [31:0] o_op1,
  output logic [31:0] o_op2,
  output logic [4:0]  o_rd,
  output logic        o_illegal
);

  // Reserved tie-off parameter; it has no function in this stage
  if (RESET_PC_UNUSED != 0) begin : g_reserved_tieoff
  end

  skid_state_e state_q, state_d;
  issue_t      m_q, m_d;
  issue_t      s_q, s_d;
  logic        ready_q, ready_d;
  issue_t      dec_entry;
  logic        in_fire;
  logic        out_fire;

  alu_issue_decode u_decode (
    .i_inst      (i_inst),
    .i_pc        (i_pc),
    .i_rs1_rdata (i_rs1_rdata),
    .i_rs2_rdata (i_rs2_rdata),
    .o_entry     (dec_entry)
  );

  assign in_fire  = i_valid && ready_q;
  assign out_fire = (state_q != ST_EMPTY) && i_ready;

  // Skid-buffer state, main/skid entries and the registered ready flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_EMPTY;
      m_q     <= '0;
      s_q     <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
      ready_q <= ready_d;
    end
  end

  // Next occupancy and entry moves; a flush overrides every handshake
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (i_flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            m_d     = dec_entry;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            m_d = dec_entry;
          end else if (in_fire) begin
            state_d = ST_TWO;
            s_d     = dec_entry;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // Input is blocked here because ready_q is low in this state
          if (out_fire) begin
            state_d = ST_ONE;
            m_d     = s_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
    ready_d = (state_d != ST_TWO);
  end

  assign o_ready    = ready_q;
  assign o_valid    = (state_q != ST_EMPTY);
  assign o_opsel    = m_q.opsel;
  assign o_sub      = m_q.sub;
  assign o_unsigned = m_q.is_unsigned;
  assign o_arith    = m_q.arith;
  assign o_op1      = m_q.op1;
  assign o_op2      = m_q.op2;
  assign o_rd       = m_q.rd;
  assign o_illegal  = m_q.illegal;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue pipeline stage that drives the ALU's control and operand inputs.
- Accepts one RV32I instruction per cycle, with its PC and register-file read data, over a valid/ready handshake.
- Decodes each instruction into ALU opsel/sub/unsigned/arith plus op1/op2, and holds the result in a 2-entry skid buffer toward the execute stage.
- o_ready is driven from a register, so it has no combinational path from i_ready.

Parameters:
- RESET_PC_UNUSED, 0, reserved tie-off; none functional. All widths are fixed at 32-bit RV32I.

Ports:
- i_clk  input  1  clock; all state updates on rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_valid  input  1  upstream instruction valid
- o_ready  output  1  stage can accept; registered
- i_inst  input  32  instruction word
- i_pc  input  32  instruction address
- i_rs1_rdata  input  32  rs1 read data
- i_rs2_rdata  input  32  rs2 read data
- i_flush  input  1  discard all held entries (branch redirect)
- o_valid  output  1  issue entry valid
- i_ready  input  1  execute stage accepts
- o_opsel  output  3  ALU opsel
- o_sub  output  1  ALU subtract
- o_unsigned  output  1  ALU unsigned compare
- o_arith  output  1  ALU arithmetic right shift
- o_op1  output  32  ALU operand 1
- o_op2  output  32  ALU operand 2
- o_rd  output  5  destination register (inst[11:7])
- o_illegal  output  1  unsupported or malformed encoding

Behaviour:
- Handshakes: transfer in on i_valid&&o_ready; transfer out on o_valid&&i_ready.
- Payload stability: o_valid and the payload must stay stable until accepted.
- Storage: main register M (drives outputs) and skid register S. States: EMPTY, ONE (M full), TWO (M and S full).
- EMPTY: in -> ONE, new entry into M.
- ONE, in and out: stay ONE, new entry into M. In only: -> TWO, new entry into S. Out only: -> EMPTY.
- TWO: o_ready=0. Out -> ONE, S moves to M.
- o_ready is registered as state != TWO.
- o_valid = state != EMPTY.
- Flush: i_flush -> EMPTY next cycle, beats presented that cycle are dropped, o_ready=1 next cycle. Flush has priority over all other events.
- Reset: asynchronous to EMPTY. o_valid=0, o_ready=1; all payload registers = 0.
- Latency: input accepted in cycle N appears on outputs in cycle N+1.
- Decode rules (f3 = inst[14:12], f7 = inst[31:25]):
  - OP 0110011: opsel=f3, op1=rs1, op2=rs2. sub=f7[5] only when f3=000. arith=f7[5] only when f3=101. unsigned=(f3==011). Illegal if f7 not in {0000000,0100000}, or f7=0100000 with f3 not in {000,101}.
  - OP-IMM 0010011: opsel=f3, op2=sign-extended inst[31:20], sub=0. Shifts use op2={27'b0,inst[24:20]}. arith=inst[30] when f3=101. Illegal if f3=001 and f7!=0, or f3=101 and f7 not in {0000000,0100000}.
  - BRANCH 1100011: opsel=010, op1=rs1, op2=rs2, unsigned=f3[1]. Illegal if f3 in {010,011}.
  - LOAD 0000011: add, op2 = I-immediate.
  - STORE 0100011: add, op2 = S-immediate {inst[31:25],inst[11:7]} sign-extended.
  - LUI 0110111: op1=0, op2={inst[31:12],12'b0}, add.
  - AUIPC 0010111: op1=pc, op2=U-immediate, add.
  - JAL 1101111 / JALR 1100111: op1=pc, op2=4, add (link value).
  - Any other opcode: o_illegal=1, controls=0, operands=0. The entry is still issued (execute raises the trap).
- Unused control bits are forced to 0 for each opcode.

Decomposition:
- Shared package alu_pkg holds opcode constants (OPC_OP, OPC_OPIMM, …), opsel encodings (ALU_ADD=000 … ALU_AND=111), and the packed issue-entry struct {opsel,sub,unsigned,arith,op1,op2,rd,illegal}.
- One purely combinational sub-module, alu_issue_decode (instruction+pc+rdata -> entry). The top level owns the skid-buffer state machine.

Test Plan:
- Reset mid-stream: assert i_rst while in TWO -> o_valid=0, o_ready=1 immediately (asynchronous). First beat after release issues correctly.
- i_inst=0x40208033 (sub x0,x1,x2), rs1=5, rs2=7 -> next cycle o_opsel=000, o_sub=1, op1=5, op2=7, o_rd=0, o_illegal=0.
- i_inst=0x40315093 (srai x1,x2,3) -> o_opsel=101, o_arith=1, o_op2=3, o_rd=1. Same with f7=0100001 -> o_illegal=1.
- i_inst=0xFFF00093 (addi x1,x0,-1) -> o_op2=0xFFFFFFFF. i_inst=0x123452B7 (lui x5) -> op1=0, op2=0x12345000, o_rd=5.
- Backpressure: hold i_ready=0, send 3 beats -> 2 accepted, o_ready=0 after the second. Release i_ready -> outputs appear in order with no loss or duplication.
- Flush while in TWO with a concurrent input beat -> next cycle o_valid=0, o_ready=1, and neither held entry nor the input beat ever appears.
